apb4_mem_slave: RTL and testbench
=================================

// Module: apb4_mem_slave
// PURPOSE
//  APB4 completer with a parametrised word-addressed memory, byte write strobes,
//  programmable wait states and address/alignment error reporting. Generalises
//  the fixed 32x32 APB RAM slave and is used as the memory target behind the APB
//  bridge and as the bus model for APB master verification.
// PARAMETERS
//  DATA_WIDTH     32  bus/word width in bits; one of 8,16,32,64
//  ADDR_WIDTH     32  paddr width in bits
//  DEPTH          32  number of DATA_WIDTH words; word index range 0..DEPTH-1
//  WAIT_STATES    0   extra access-phase cycles before pready; 0..15
//  CLEAR_ON_RESET 1   1: all words cleared to 0 by reset; 0: contents kept
// PORTS
//  pclk     in   1              clock; all logic on rising edge
//  preset   in   1              synchronous, active-high reset
//  psel     in   1              completer select
//  penable  in   1              access phase indicator
//  pwrite   in   1              1 write, 0 read
//  paddr    in   ADDR_WIDTH     byte address
//  pwdata   in   DATA_WIDTH     write data
//  pstrb    in   DATA_WIDTH/8   write byte strobes; ignored on reads
//  prdata   out  DATA_WIDTH     read data, valid only while pready=1 on a read
//  pready   out  1              transfer complete (registered)
//  pslverr  out  1              transfer error, valid only while pready=1
// BEHAVIOUR
//  Reset: state IDLE, pready=0, pslverr=0, prdata=0, wait counter=0; memory
//   cleared only if CLEAR_ON_RESET=1. Reset wins over every other event, incl.
//   mid-transfer: transfer dropped, no memory update.
//  LSB = log2(DATA_WIDTH/8); word index idx = paddr[ADDR_WIDTH-1:LSB].
//  err = (paddr[LSB-1:0] != 0) || (idx >= DEPTH); for DATA_WIDTH=8 only range.
//  FSM states IDLE, WAIT, DONE:
//   IDLE: on psel&penable: if WAIT_STATES==0 -> DONE (execute), else
//    cnt<=WAIT_STATES-1 -> WAIT. Setup phase (psel&!penable) is not acted on.
//   WAIT: if !psel -> IDLE (abort, no access, pready stays 0);
//    elif cnt==0 -> DONE (execute); else cnt<=cnt-1.
//   DONE: pready=1 for exactly one cycle; next cycle -> IDLE, pready=0,
//    pslverr=0, prdata=0. Back-to-back transfer needs a new access phase.
//  Execute (on the edge entering DONE, using paddr/pwrite/pwdata sampled then):
//   write, !err: byte b of mem[idx] <= pwdata byte b for each pstrb[b]=1;
//    pstrb=0 is a legal no-op write; pslverr<=0.
//   write, err: memory unchanged; pslverr<=1.
//   read, !err: prdata<=mem[idx]; pslverr<=0.
//   read, err: prdata<=0 (never X); pslverr<=1.
//  Latency: pready high WAIT_STATES+1 cycles after first cycle with psel&penable.
//  Master must hold paddr/pwrite/pwdata/pstrb stable through access phase; if
//   changed during WAIT, values at the executing edge are used.
//  pready/pslverr/prdata never change outside the state rules above.
// TESTING
//  1 Reset, WAIT_STATES=0: write 0xDEADBEEF @0x04 strb=F, read @0x04 ->
//    pready 1 cycle after access start, prdata=0xDEADBEEF, pslverr=0.
//  2 Byte strobes: write 0x11223344 @0x08 strb=F, then 0xAABBCCDD strb=0x5 ->
//    read @0x08 returns 0x11BB33DD.
//  3 Errors (DEPTH=32): read @0x80 -> pslverr=1, prdata=0; write @0x06 ->
//    pslverr=1 and word 1 unchanged on readback.
//  4 WAIT_STATES=3: pready rises exactly 4 cycles after psel&penable first
//    seen; drop psel in WAIT -> no pready, no write (readback old value).
//  5 preset asserted in WAIT of write 0x5A5A5A5A @0 -> pready=0 next cycle,
//    readback @0 = 0 (CLEAR_ON_RESET=1), FSM accepts next transfer normally.
//  6 DATA_WIDTH=64, DEPTH=16: write all words, read back; @0x7C -> pslverr=1.

Source files
------------

// File: rtl/apb4_mem_slave.sv
// apb4_mem_slave: APB4 completer backed by a word-addressed memory.
// Supports byte write strobes, programmable wait states and error responses
// for misaligned or out-of-range addresses. All outputs are registered.
module apb4_mem_slave #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int DEPTH          = 32,
    parameter int WAIT_STATES    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Low address bits that must be zero for a word-aligned access
    // (all-zero mask for 8-bit data, where every byte address is a word).
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
    localparam logic [3:0]            CNT_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    exec;

    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [IDX_W-1:0]        mem_idx;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    err;
    logic [DATA_WIDTH-1:0]   wmask;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Address decode: word index plus alignment and range checks.
    assign word_idx     = paddr >> LSB;
    assign mem_idx      = word_idx[IDX_W-1:0];
    assign misaligned   = |(paddr & ALIGN_MASK);
    assign out_of_range = (word_idx >= DEPTH_A);
    assign err          = misaligned || out_of_range;

    // Strobes expanded to a bit mask so the write is a single masked merge.
    for (genvar b = 0; b < NBYTES; b++) begin : g_wmask
        assign wmask[8*b +: 8] = {8{pstrb[b]}};
    end

    // State register and wait-state counter.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; exec marks the edge on which the access is performed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exec    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (psel && penable) begin
                    if (WAIT_STATES == 0) begin
                        state_d = DONE;
                        exec    = 1'b1;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                    exec    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory array: optional clear on reset, strobed write on a good access.
    always_ff @(posedge pclk) begin
        if (preset) begin
            if (CLEAR_ON_RESET != 0) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem[IDX_W'(i)] <= '0;
                end
            end
        end else if (exec && pwrite && !err) begin
            mem[mem_idx] <= (mem[mem_idx] & ~wmask) | (pwdata & wmask);
        end
    end

    // Response registers: high for exactly the cycle after the executing edge.
    always_ff @(posedge pclk) begin
        if (preset) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            pready  <= exec;
            pslverr <= exec && err;
            prdata  <= (exec && !pwrite && !err) ? mem[mem_idx] : '0;
        end
    end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// tb_apb4_mem_slave: three instances (32-bit/0 waits, 32-bit/3 waits,
// 64-bit/16 words/1 wait) on a shared bus with per-instance select.
// A reference memory and a latency rule predict every output every cycle.
module tb_apb4_mem_slave;

    logic        pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        preset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;

    logic [31:0] prdata0, prdata1;
    logic [63:0] prdata2;
    logic        pready0, pready1, pready2;
    logic        pslverr0, pslverr1, pslverr2;

    apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(0), .CLEAR_ON_RESET(1)) dut0 (
        .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata[31:0]), .pstrb(pstrb[3:0]),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

    apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(3), .CLEAR_ON_RESET(1)) dut1 (
        .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata[31:0]), .pstrb(pstrb[3:0]),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1));

    apb4_mem_slave #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(1), .CLEAR_ON_RESET(1)) dut2 (
        .pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata2), .pready(pready2), .pslverr(pslverr2));

    logic [63:0] act_rd  [3];
    logic        act_rdy [3];
    logic        act_err [3];
    assign act_rd[0]  = {32'd0, prdata0};
    assign act_rd[1]  = {32'd0, prdata1};
    assign act_rd[2]  = prdata2;
    assign act_rdy[0] = pready0;
    assign act_rdy[1] = pready1;
    assign act_rdy[2] = pready2;
    assign act_err[0] = pslverr0;
    assign act_err[1] = pslverr1;
    assign act_err[2] = pslverr2;

    // Reference model state.
    int          nb_of    [3] = '{4, 4, 8};
    int          depth_of [3] = '{32, 32, 16};
    int          ws_of    [3] = '{0, 3, 1};
    logic [63:0] mem_m    [3][32];
    logic [63:0] exp_rd   [3];
    logic        exp_rdy  [3];
    logic        exp_err  [3];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic cmp_all();
        for (int d = 0; d < 3; d++) begin
            check64($sformatf("dut%0d pready", d),  {63'd0, act_rdy[d]}, {63'd0, exp_rdy[d]});
            check64($sformatf("dut%0d pslverr", d), {63'd0, act_err[d]}, {63'd0, exp_err[d]});
            check64($sformatf("dut%0d prdata", d),  act_rd[d], exp_rd[d]);
        end
    endtask

    function automatic bit model_err(input int d, input int unsigned a);
        return ((a % nb_of[d]) != 0) || ((a / nb_of[d]) >= depth_of[d]);
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 32; i++)
                mem_m[d][i] = 64'd0;
    endtask

    // One complete transfer; the model predicts the response, pready being due
    // WAIT_STATES+1 cycles after the first access-phase cycle.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [63:0] data, input logic [7:0] strb,
                        output logic [63:0] rd_act, output logic err_act);
        logic [63:0] e_rd;
        logic        e_err;
        int unsigned idx;
        @(posedge pclk); #1;
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        e_err = model_err(d, addr);
        e_rd  = 64'd0;
        if (!e_err) begin
            idx = addr / nb_of[d];
            if (wr) begin
                for (int b = 0; b < nb_of[d]; b++)
                    if (strb[b]) mem_m[d][idx][b*8 +: 8] = data[b*8 +: 8];
            end else begin
                e_rd = mem_m[d][idx];
            end
        end
        repeat (ws_of[d] + 1) @(posedge pclk);
        #1;
        exp_rdy[d] = 1'b1; exp_err[d] = e_err; exp_rd[d] = wr ? 64'd0 : e_rd;
        @(negedge pclk);
        rd_act  = act_rd[d];
        err_act = act_err[d];
        @(posedge pclk); #1;
        psel[d] = 1'b0; penable = 1'b0;
        exp_rdy[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = 64'd0;
    endtask

    task automatic do_write(input int d, input logic [31:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input logic lit_err, input string name);
        logic [63:0] rd;
        logic        e;
        xfer(d, 1'b1, addr, data, strb, rd, e);
        check64({name, " pslverr"}, {63'd0, e}, {63'd0, lit_err});
    endtask

    task automatic do_read(input int d, input logic [31:0] addr, input logic [63:0] lit_rd,
                           input logic lit_err, input string name);
        logic [63:0] rd;
        logic        e;
        xfer(d, 1'b0, addr, 64'd0, 8'h00, rd, e);
        check64({name, " prdata"}, rd, lit_rd);
        check64({name, " pslverr"}, {63'd0, e}, {63'd0, lit_err});
    endtask

    // Access phase started, then psel dropped while still waiting.
    task automatic abort_write(input int d, input logic [31:0] addr, input logic [63:0] data);
        @(posedge pclk); #1;
        psel[d] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data; pstrb = 8'hFF;
        @(posedge pclk); #1; penable = 1'b1;
        @(posedge pclk); #1;
        @(posedge pclk); #1; psel[d] = 1'b0; penable = 1'b0;
        repeat (4) @(posedge pclk);
        #1;
    endtask

    // Reset pulse while the write sits in its wait states.
    task automatic reset_in_wait(input int d, input logic [31:0] addr, input logic [63:0] data);
        @(posedge pclk); #1;
        psel[d] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data; pstrb = 8'hFF;
        @(posedge pclk); #1; penable = 1'b1;
        @(posedge pclk); #1; preset = 1'b1;
        @(posedge pclk); #1; preset = 1'b0; psel[d] = 1'b0; penable = 1'b0;
        clear_model();
        repeat (4) @(posedge pclk);
        #1;
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h0101_0101_0101_0101);
    endfunction

    initial begin
        preset = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        for (int d = 0; d < 3; d++) begin
            exp_rd[d] = 64'd0; exp_rdy[d] = 1'b0; exp_err[d] = 1'b0;
        end
        clear_model();

        fork
            forever begin
                @(negedge pclk);
                if (chk_en) cmp_all();
            end
        join_none

        repeat (2) @(posedge pclk);
        #1 chk_en = 1'b1;
        @(negedge pclk);
        check64("reset pready0",  {63'd0, pready0},  64'd0);
        check64("reset pslverr1", {63'd0, pslverr1}, 64'd0);
        check64("reset prdata2",  prdata2,           64'd0);
        @(posedge pclk); #1 preset = 1'b0;

        // Basic write/read, no wait states.
        do_write(0, 32'h04, 64'hDEADBEEF, 8'h0F, 1'b0, "t1 wr");
        do_read (0, 32'h04, 64'hDEADBEEF, 1'b0, "t1 rd");

        // Byte strobes, including an all-zero strobe no-op.
        do_write(0, 32'h08, 64'h11223344, 8'h0F, 1'b0, "t2 wr full");
        do_write(0, 32'h08, 64'hAABBCCDD, 8'h05, 1'b0, "t2 wr strb5");
        do_read (0, 32'h08, 64'h11BB33DD, 1'b0, "t2 rd");
        do_write(0, 32'h08, 64'hFFFFFFFF, 8'h00, 1'b0, "t2 wr strb0");
        do_read (0, 32'h08, 64'h11BB33DD, 1'b0, "t2 rd after strb0");

        // Error responses and range boundary.
        do_read (0, 32'h80, 64'd0, 1'b1, "t3 rd oor");
        do_write(0, 32'h06, 64'h55555555, 8'h0F, 1'b1, "t3 wr misaligned");
        do_read (0, 32'h04, 64'hDEADBEEF, 1'b0, "t3 rd word1");
        do_read (0, 32'h7C, 64'd0, 1'b0, "t3 rd last unwritten");
        do_write(0, 32'h7C, 64'h13579BDF, 8'h0F, 1'b0, "t3 wr last");
        do_read (0, 32'h7C, 64'h13579BDF, 1'b0, "t3 rd last");

        // Three wait states, then an aborted write.
        do_write(1, 32'h00, 64'h12345678, 8'h0F, 1'b0, "t4 wr");
        do_read (1, 32'h00, 64'h12345678, 1'b0, "t4 rd");
        abort_write(1, 32'h00, 64'hCAFEF00D);
        do_read (1, 32'h00, 64'h12345678, 1'b0, "t4 rd after abort");
        do_read (1, 32'h81, 64'd0, 1'b1, "t4 rd err");

        // Reset during the wait states of a write.
        reset_in_wait(1, 32'h00, 64'h5A5A5A5A);
        do_read (1, 32'h00, 64'd0, 1'b0, "t5 rd after reset");
        do_read (0, 32'h04, 64'd0, 1'b0, "t5 rd dut0 cleared");
        do_write(1, 32'h04, 64'h0BADCAFE, 8'h0F, 1'b0, "t5 wr");
        do_read (1, 32'h04, 64'h0BADCAFE, 1'b0, "t5 rd");

        // 64-bit instance: fill, read back, partial strobe, errors.
        for (int i = 0; i < 16; i++)
            do_write(2, 32'(i * 8), pat(i), 8'hFF, 1'b0, $sformatf("t6 wr%0d", i));
        for (int i = 0; i < 16; i++)
            do_read(2, 32'(i * 8), pat(i), 1'b0, $sformatf("t6 rd%0d", i));
        do_write(2, 32'h08, 64'hFFFF_FFFF_0000_0000, 8'hF0, 1'b0, "t6 wr upper");
        do_read (2, 32'h08, {32'hFFFF_FFFF, pat(1)[31:0]}, 1'b0, "t6 rd upper");
        do_read (2, 32'h7C, 64'd0, 1'b1, "t6 rd misaligned");
        do_read (2, 32'h80, 64'd0, 1'b1, "t6 rd oor");

        repeat (3) @(posedge pclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
